fill_supply_arbiter: RTL and testbench

Round-robin arbiter that shares one building water-supply line among `N_MACHINES` washing-machine controllers. Each controller's `input_valve` request drives one `req` bit. The arbiter grants the supply to one machine at a time and enforces a maximum slot length when others are waiting. It inserts a valve-changeover gap between owners and drives the master supply valve. It sits between the per-machine controllers and the plumbing actuators.

---
 rtl/awmc_pkg.sv | 40 ++++
 rtl/fill_supply_arbiter_rr_pick.sv | 40 ++++
 rtl/fill_supply_arbiter.sv | 159 +++++++++++++++
 tb/tb_fill_supply_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/awmc_pkg.sv
// Shared package for the washing-machine controller codebase.
// Purpose: supply-arbiter state encoding, default parameter constants and the
//          per-machine controller stage codes, so every block agrees on them.
// Contents:
//   arb_state_e   - supply arbiter states (IDLE / GRANT / GAP)
//   wash_stage_e  - stage codes used by the per-machine wash controller
//   DEFAULT_*     - default arbiter parameters
//   wrap_inc      - modulo increment helper for round-robin indices
package awmc_pkg;

  // Supply arbiter state encoding. The codes are fixed so that state can be
  // observed on debug buses with a stable meaning.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_e;

  // Stage codes of the per-machine wash controller.
  typedef enum logic [2:0] {
    STAGE_IDLE  = 3'd0,
    STAGE_FILL  = 3'd1,
    STAGE_WASH  = 3'd2,
    STAGE_DRAIN = 3'd3,
    STAGE_RINSE = 3'd4,
    STAGE_SPIN  = 3'd5,
    STAGE_DONE  = 3'd6,
    STAGE_FAULT = 3'd7
  } wash_stage_e;

  localparam int DEFAULT_N_MACHINES  = 4;
  localparam int DEFAULT_SLOT_CYCLES = 8;
  localparam int DEFAULT_GAP_CYCLES  = 1;

  // Increment an index modulo n (n need not be a power of two).
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fill_supply_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Purpose: find the first set bit of req searching upward from ptr and
//          wrapping modulo N.
// Ports:
//   req   [N-1:0]   - request vector
//   ptr   [ID_W-1:0]- search start index (0..N-1)
//   valid           - at least one request bit is set
//   idx   [ID_W-1:0]- picked index (0 when !valid)
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  // One extra bit so ptr+k (at most 2N-2) never overflows before wrapping.
  logic [ID_W:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (ID_W + 1)'(k);
      if (pos >= (ID_W + 1)'(N)) begin
        pos = pos - (ID_W + 1)'(N);
      end
      if (req[pos[ID_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fill_supply_arbiter.sv
// fill_supply_arbiter: round-robin arbiter sharing one building water-supply
// line among N_MACHINES washing-machine controllers.
// Purpose: grant one machine at a time, cap a slot at SLOT_CYCLES when others
//          wait, insert a GAP_CYCLES valve-changeover gap between owners and
//          drive the master supply valve.
// Ports:
//   clk          - clock, all state changes on the rising edge
//   reset        - asynchronous, active-high reset; closes all valves at once
//   req          - level request per machine
//   grant        - registered branch-valve enables, one-hot or zero
//   supply_valve - registered master valve, always equal to |grant
//   active_id    - index of the current or last owner
//   busy         - arbiter is not idle
//   preempt      - one-cycle pulse when a slot ends by expiry
module fill_supply_arbiter
  import awmc_pkg::*;
#(
  parameter int N_MACHINES  = DEFAULT_N_MACHINES,
  parameter int SLOT_CYCLES = DEFAULT_SLOT_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int ID_W        = (N_MACHINES > 1) ? $clog2(N_MACHINES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_MACHINES-1:0] req,
  output logic [N_MACHINES-1:0] grant,
  output logic                  supply_valve,
  output logic [ID_W-1:0]       active_id,
  output logic                  busy,
  output logic                  preempt
);

  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_e       state;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  ptr;
  logic [SLOT_W-1:0] slot_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic                  pick_valid;
  logic [ID_W-1:0]       pick_idx;
  logic [N_MACHINES-1:0] others;
  logic                  other_pending;
  logic                  slot_last;
  logic                  gap_last;
  logic [ID_W-1:0]       next_ptr;

  // Requests from everyone except the current owner; decides whether an
  // expiring slot is preempted or silently renewed.
  generate
    for (genvar gi = 0; gi < N_MACHINES; gi++) begin : g_others
      assign others[gi] = req[gi] & (owner != ID_W'(gi));
    end
  endgenerate

  assign other_pending = |others;

  rr_pick #(
    .N    (N_MACHINES),
    .ID_W (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign slot_last = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
  assign gap_last  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign next_ptr  = (owner == ID_W'(N_MACHINES - 1)) ? '0 : owner + ID_W'(1);

  // owner doubles as "last owner", which is exactly what active_id reports.
  assign active_id = owner;
  // Derived from the state register so it also drops the moment reset hits.
  assign busy      = (state != IDLE);

  function automatic logic [N_MACHINES-1:0] onehot(input logic [ID_W-1:0] i);
    logic [N_MACHINES-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= '0;
      ptr          <= '0;
      slot_cnt     <= '0;
      gap_cnt      <= '0;
      grant        <= '0;
      supply_valve <= 1'b0;
      preempt      <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner        <= pick_idx;
            slot_cnt     <= '0;
            grant        <= onehot(pick_idx);
            supply_valve <= 1'b1;
            state        <= GRANT;
          end
        end

        GRANT: begin
          if (!req[owner]) begin
            // Release wins over expiry: no pulse, pointer still moves on.
            state        <= GAP;
            gap_cnt      <= '0;
            ptr          <= next_ptr;
            grant        <= '0;
            supply_valve <= 1'b0;
          end else if (slot_last && other_pending) begin
            state        <= GAP;
            gap_cnt      <= '0;
            ptr          <= next_ptr;
            grant        <= '0;
            supply_valve <= 1'b0;
            preempt      <= 1'b1;
          end else if (slot_last) begin
            // Nobody else waiting: renew without closing the valve.
            slot_cnt <= '0;
          end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
          end
        end

        GAP: begin
          // Requests are only looked at on the exit edge of the gap.
          if (gap_last) begin
            gap_cnt <= '0;
            if (pick_valid) begin
              owner        <= pick_idx;
              slot_cnt     <= '0;
              grant        <= onehot(pick_idx);
              supply_valve <= 1'b1;
              state        <= GRANT;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state        <= IDLE;
          grant        <= '0;
          supply_valve <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fill_supply_arbiter.sv
// Self-checking bench for fill_supply_arbiter.
// A driver applies directed scenarios followed by random request traffic;
// for every edge it pushes the outputs predicted by a cycle-level model of
// the arbitration rules into a queue. An independent monitor pops one entry
// after each rising edge and compares it with the DUT outputs.
module tb_fill_supply_arbiter;

  localparam int N    = 4;
  localparam int SLOT = 8;
  localparam int GAP  = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic         supply_valve;
  logic [1:0]   active_id;
  logic         busy;
  logic         preempt;

  fill_supply_arbiter #(
    .N_MACHINES  (N),
    .SLOT_CYCLES (SLOT),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .grant        (grant),
    .supply_valve (supply_valve),
    .active_id    (active_id),
    .busy         (busy),
    .preempt      (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic         supply;
    logic         busy;
    int           id;
    logic         preempt;
    logic [N-1:0] req;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  // Reference model: owner = -1 means nobody holds the supply.
  // used = grant cycles consumed in the current slot (including the coming one),
  // gap_left = gap cycles remaining including the coming one.
  int m_owner, m_used, m_gap, m_ptr, m_last;
  bit m_pre;

  function automatic void model_reset();
    m_owner = -1; m_used = 0; m_gap = 0; m_ptr = 0; m_last = 0; m_pre = 0;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [N-1:0] r);
    int p;
    logic [N-1:0] rest;
    m_pre = 0;
    if (m_owner >= 0) begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (!r[m_owner] || (m_used == SLOT && rest != 0)) begin
        m_pre   = r[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = GAP;
      end else if (m_used == SLOT) begin
        m_used = 1;
      end else begin
        m_used++;
      end
    end else if (m_gap > 0) begin
      if (m_gap == 1) begin
        m_gap = 0;
        p = pick(r, m_ptr);
        if (p >= 0) begin m_owner = p; m_last = p; m_used = 1; end
      end else begin
        m_gap--;
      end
    end else begin
      p = pick(r, m_ptr);
      if (p >= 0) begin m_owner = p; m_last = p; m_used = 1; end
    end
  endfunction

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%0h required=%0h", name, txn, act, want);
    end
  endtask

  // Apply r for the coming edge and queue the predicted outputs.
  task automatic step_now(input logic [N-1:0] r);
    exp_t e;
    req = r;
    model_step(r);
    e.grant   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.supply  = (m_owner >= 0);
    e.busy    = (m_owner >= 0) || (m_gap > 0);
    e.id      = m_last;
    e.preempt = m_pre;
    e.req     = r;
    q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] r);
    @(negedge clk);
    step_now(r);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"},   int'(grant), 0);
    check({tag, "_supply"},  int'(supply_valve), 0);
    check({tag, "_busy"},    int'(busy), 0);
    check({tag, "_preempt"}, int'(preempt), 0);
    check({tag, "_id"},      int'(active_id), 0);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: one comparison set per rising edge that has a queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        txn++;
        $display("txn %0d req=%b grant=%b exp=%b preempt=%b busy=%b id=%0d",
                 txn, e.req, grant, e.grant, preempt, busy, active_id);
        check("grant",        int'(grant), int'(e.grant));
        check("supply_valve", int'(supply_valve), int'(e.supply));
        check("busy",         int'(busy), int'(e.busy));
        check("active_id",    int'(active_id), e.id);
        check("preempt",      int'(preempt), int'(e.preempt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog txn=%0d actual=timeout required=finish", txn);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Single requester: renewed slots, no gaps, no preempt.
    repeat (20) step(4'b0100);

    // Two requesters contend: 8-cycle slots with one-cycle gaps.
    hard_reset();
    repeat (30) step(4'b0011);

    // Early release of owner 0 before edge 4.
    hard_reset();
    repeat (3) step(4'b1001);
    repeat (6) step(4'b1000);

    // Wrap-around: owner 3 contended with machine 0.
    hard_reset();
    repeat (2) step(4'b1000);
    repeat (14) step(4'b1001);

    // Release on the same edge as slot expiry.
    hard_reset();
    repeat (8) step(4'b0011);
    repeat (5) step(4'b0010);

    // Asynchronous reset in cycle 5 of a slot.
    hard_reset();
    repeat (5) step(4'b0100);
    @(posedge clk);
    #3;
    reset = 1'b1;
    req   = '0;
    model_reset();
    #1;
    check("async_grant",  int'(grant), 0);
    check("async_supply", int'(supply_valve), 0);
    check("async_busy",   int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    step_now(4'b0010);
    repeat (3) step(4'b0010);

    // Random traffic with persistent requests that toggle occasionally.
    hard_reset();
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 63) == 0) r = '0;
      step(r);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
